// File: rtl/tmds_decoder.sv
// TMDS 10b/8b decoder with a control-token lock FSM and a two-stage datapath.
// Optional bit-slip search is built when macro TMDS_DECODER_BITSLIP_EN is defined.
module tmds_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int SLIP_WORDS  = 1024,
  parameter int LOSS_WORDS  = 2048
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic       bitslip_out
);
  localparam int MAX_LS = (LOCK_TOKENS > SLIP_WORDS) ? LOCK_TOKENS : SLIP_WORDS;
  localparam int MAX_P  = (MAX_LS > LOSS_WORDS) ? MAX_LS : LOSS_WORDS;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // {hit, c1, c0}
  function automatic logic [2:0] token_match(input logic [9:0] w);
    case (w)
      10'b1101010100: token_match = 3'b100;
      10'b0010101011: token_match = 3'b101;
      10'b0101010100: token_match = 3'b110;
      10'b1010101011: token_match = 3'b111;
      default:        token_match = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] decode_word(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] r;
    d = w[9] ? ~w[7:0] : w[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++)
      r[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] lim);
    return (c >= lim) ? c : c + CNT_W'(1);
  endfunction

  logic [2:0]       match;
  logic [9:0]       word_p1_d, word_p1_q;
  logic             tok_p1_d, tok_p1_q;
  logic [1:0]       tokval_p1_d, tokval_p1_q;
  logic [7:0]       data_p2_d, data_p2_q;
  logic [1:0]       ctrl_p2_d, ctrl_p2_q;
  logic             ve_p2_d, ve_p2_q;
  logic [0:0]       state_d, state_q;
  logic [CNT_W-1:0] run_cnt_d, run_cnt_q;
  logic [CNT_W-1:0] loss_cnt_d, loss_cnt_q;
  logic             bitslip_d, bitslip_q;
`ifdef TMDS_DECODER_BITSLIP_EN
  logic [CNT_W-1:0] slip_cnt_d, slip_cnt_q;
`endif

  // stage 1: register raw word and token match
  always_comb begin
    match       = token_match(tmds_in);
    word_p1_d   = tmds_in;
    tok_p1_d    = match[2];
    tokval_p1_d = match[1:0];
  end

  // stage 2: decode, gated by the state seen on this edge so the in-flight word at lock is masked
  always_comb begin
    data_p2_d = 8'd0;
    ctrl_p2_d = 2'b00;
    ve_p2_d   = 1'b0;
    if (state_q == ST_LOCKED) begin
      ctrl_p2_d = ctrl_p2_q;
      if (tok_p1_q) begin
        ctrl_p2_d = tokval_p1_q;
      end else begin
        ve_p2_d   = 1'b1;
        data_p2_d = decode_word(word_p1_q);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    loss_cnt_d = loss_cnt_q;
    bitslip_d  = 1'b0;
`ifdef TMDS_DECODER_BITSLIP_EN
    slip_cnt_d = slip_cnt_q;
`endif
    if (state_q == ST_SEARCH) begin
      // lock is tested before slip so a simultaneous completion never pulses bitslip
      if (run_cnt_q == CNT_W'(LOCK_TOKENS)) begin
        state_d    = ST_LOCKED;
        run_cnt_d  = '0;
        loss_cnt_d = '0;
`ifdef TMDS_DECODER_BITSLIP_EN
        slip_cnt_d = '0;
      end else if (slip_cnt_q == CNT_W'(SLIP_WORDS - 1)) begin
        bitslip_d  = 1'b1;
        slip_cnt_d = '0;
        run_cnt_d  = '0;
`endif
      end else begin
        run_cnt_d  = tok_p1_q ? sat_inc(run_cnt_q, CNT_W'(LOCK_TOKENS)) : '0;
`ifdef TMDS_DECODER_BITSLIP_EN
        slip_cnt_d = sat_inc(slip_cnt_q, CNT_W'(SLIP_WORDS - 1));
`endif
      end
    end else begin
      if (loss_cnt_q == CNT_W'(LOSS_WORDS)) begin
        state_d    = ST_SEARCH;
        run_cnt_d  = '0;
        loss_cnt_d = '0;
      end else begin
        loss_cnt_d = tok_p1_q ? '0 : sat_inc(loss_cnt_q, CNT_W'(LOSS_WORDS));
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_p1_q   <= '0;
      tok_p1_q    <= 1'b0;
      tokval_p1_q <= 2'b00;
      data_p2_q   <= 8'd0;
      ctrl_p2_q   <= 2'b00;
      ve_p2_q     <= 1'b0;
      state_q     <= ST_SEARCH;
      run_cnt_q   <= '0;
      loss_cnt_q  <= '0;
      bitslip_q   <= 1'b0;
`ifdef TMDS_DECODER_BITSLIP_EN
      slip_cnt_q  <= '0;
`endif
    end else begin
      word_p1_q   <= word_p1_d;
      tok_p1_q    <= tok_p1_d;
      tokval_p1_q <= tokval_p1_d;
      data_p2_q   <= data_p2_d;
      ctrl_p2_q   <= ctrl_p2_d;
      ve_p2_q     <= ve_p2_d;
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      bitslip_q   <= bitslip_d;
`ifdef TMDS_DECODER_BITSLIP_EN
      slip_cnt_q  <= slip_cnt_d;
`endif
    end
  end

  assign data_out    = data_p2_q;
  assign control_out = ctrl_p2_q;
  assign ve_out      = ve_p2_q;
  assign locked_out  = (state_q == ST_LOCKED);
  assign bitslip_out = bitslip_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: behavioural reference model compared every cycle,
// plus directed literal checks. Bit-slip checks follow TMDS_DECODER_BITSLIP_EN.
module tb_tmds_decoder;
  localparam int LOCK_T = 8;
  localparam int SLIP_W = 16;
  localparam int LOSS_W = 2048;
`ifdef TMDS_DECODER_BITSLIP_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] tmds;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out, locked_out, bitslip_out;

  always #5 clk = ~clk;

  tmds_decoder #(.LOCK_TOKENS(LOCK_T), .SLIP_WORDS(SLIP_W), .LOSS_WORDS(LOSS_W)) dut (
    .clk_in(clk), .rst_in(rst), .tmds_in(tmds), .data_out(data_out),
    .control_out(control_out), .ve_out(ve_out), .locked_out(locked_out),
    .bitslip_out(bitslip_out)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] tok_word(input int v);
    case (v)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic bit is_token(input logic [9:0] w, output int v);
    v = 0;
    for (int k = 0; k < 4; k++)
      if (w == tok_word(k)) begin
        v = k;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int ref_decode(input logic [9:0] w);
    int d, r, b;
    d = int'(w[7:0]);
    if (w[9]) d = d ^ 255;
    r = d & 1;
    for (int i = 1; i < 8; i++) begin
      b = ((d >> i) & 1) ^ ((d >> (i - 1)) & 1);
      if (!w[8]) b = b ^ 1;
      r = r | (b << i);
    end
    return r;
  endfunction

  // reference model: one word of pipeline history plus lock/slip/loss bookkeeping
  int m_lock, m_run, m_slip, m_loss;
  logic [9:0] m_s1;
  int e_data, e_ctrl, e_ve, e_lock, e_slip;

  always @(posedge clk) begin
    int tv;
    bit tk;
    if (rst) begin
      m_lock = 0; m_run = 0; m_slip = 0; m_loss = 0; m_s1 = '0;
      e_data = 0; e_ctrl = 0; e_ve = 0; e_lock = 0; e_slip = 0;
    end else begin
      tk = is_token(m_s1, tv);
      if (m_lock != 0) begin
        if (tk) begin e_ve = 0; e_data = 0; e_ctrl = tv; end
        else begin e_ve = 1; e_data = ref_decode(m_s1); end
      end else begin
        e_ve = 0; e_data = 0; e_ctrl = 0;
      end
      e_slip = 0;
      if (m_lock == 0) begin
        if (m_run >= LOCK_T) begin
          m_lock = 1; m_run = 0; m_slip = 0; m_loss = 0;
        end else if (SLIP_EN && m_slip >= SLIP_W - 1) begin
          e_slip = 1; m_slip = 0; m_run = 0;
        end else begin
          m_run = tk ? m_run + 1 : 0;
          if (SLIP_EN) m_slip = m_slip + 1;
        end
      end else begin
        if (m_loss >= LOSS_W) begin
          m_lock = 0; m_loss = 0; m_run = 0; m_slip = 0;
        end else begin
          m_loss = tk ? 0 : m_loss + 1;
        end
      end
      e_lock = m_lock;
      m_s1 = tmds;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", int'(data_out), e_data);
      check("control_out", int'(control_out), e_ctrl);
      check("ve_out", int'(ve_out), e_ve);
      check("locked_out", int'(locked_out), e_lock);
      check("bitslip_out", int'(bitslip_out), e_slip);
    end
  end

  task automatic drive(input logic [9:0] w);
    @(negedge clk);
    tmds = w;
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    int v;
    w = 10'($urandom);
    while (is_token(w, v)) w = 10'($urandom);
    return w;
  endfunction

  int pulses, lost, ctrl;

  initial begin
    rst = 1'b1;
    tmds = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_locked", int'(locked_out), 0);
    check("reset_ve", int'(ve_out), 0);
    check("reset_data", int'(data_out), 0);
    rst = 1'b0;

    // acquire lock on control token 00
    repeat (9) drive(tok_word(0));
    check("lock_not_yet", int'(locked_out), 0);
    repeat (3) drive(tok_word(0));
    check("lock_after_8", int'(locked_out), 1);
    check("lock_ctrl00", int'(control_out), 0);
    check("lock_ve0", int'(ve_out), 0);

    // two-cycle latency on known words
    drive(10'h100);
    drive(tok_word(0));
    check("h100_not_early", int'(ve_out), 0);
    drive(tok_word(0));
    check("h100_ve", int'(ve_out), 1);
    check("h100_data", int'(data_out), 8'h00);
    drive(10'h2FF);
    drive(tok_word(0));
    check("h2ff_not_early", int'(ve_out), 0);
    drive(tok_word(0));
    check("h2ff_ve", int'(ve_out), 1);
    check("h2ff_data", int'(data_out), 8'hFE);

    // 720p-style lines with random {vsync,hsync}
    lost = 0;
    for (int ln = 0; ln < 3; ln++) begin
      ctrl = int'($urandom_range(0, 3));
      repeat (4) begin drive(tok_word(ctrl)); if (!locked_out) lost = 1; end
      repeat (1280) begin drive(rand_data()); if (!locked_out) lost = 1; end
      repeat (366) begin drive(tok_word(ctrl)); if (!locked_out) lost = 1; end
      check("line_ctrl", int'(control_out), ctrl);
    end
    check("lines_lock_held", lost, 0);

    // random mix while locked
    repeat (600) begin
      if ($urandom_range(0, 1) == 1) drive(tok_word(int'($urandom_range(0, 3))));
      else drive(rand_data());
    end

    // loss of lock
    repeat (LOSS_W + 8) drive(rand_data());
    check("loss_unlocked", int'(locked_out), 0);

    // constant non-token in SEARCH
    pulses = 0;
    repeat (48) begin
      drive(10'h155);
      if (bitslip_out) pulses++;
    end
    check("slip_pulses", pulses, SLIP_EN ? 3 : 0);
    check("slip_unlocked", int'(locked_out), 0);

    // one-cycle reset mid-SEARCH
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_data", int'(data_out), 0);
    check("rst_ctrl", int'(control_out), 0);
    check("rst_ve", int'(ve_out), 0);
    check("rst_locked", int'(locked_out), 0);
    check("rst_slip", int'(bitslip_out), 0);
    rst = 1'b0;
    repeat (12) drive(tok_word(2));
    check("relock", int'(locked_out), 1);
    check("relock_ctrl", int'(control_out), 2);

    // random search/lock traffic with occasional token-run breaks
    repeat (2500) begin
      if ($urandom_range(0, 15) != 0) drive(tok_word(int'($urandom_range(0, 3))));
      else drive(rand_data());
    end
    repeat (3) drive(10'h000);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
